ring_mod_preset_sequencer: RTL and testbench

- Parametrised successor to the ring-modulation frequency controller.
- Two active-low push keys (down/up) step through a table of NUM_PRESETS carrier-frequency presets.
- Keys are synchronised and debounced; saturating or wrapping index; selectable effect ID; registered frequency, preset index, change strobe and disable outputs.
- Sits between the board keys/switches and the ring-modulation carrier generator.

---
 rtl/ring_mod_preset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ring_mod_preset_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ring_mod_preset_sequencer.sv
// Key-driven carrier-frequency preset selector for the ring-modulation effect.
// Optional auto-repeat on held keys is built when RING_MOD_AUTO_REPEAT_EN is defined.
module ring_mod_preset_sequencer #(
  parameter int FREQ_W          = 32,
  parameter int NUM_PRESETS     = 8,
  parameter int IDX_W           = 4,
  parameter logic [NUM_PRESETS*FREQ_W-1:0] PRESET_TABLE = {
    32'd4111, 32'd3551, 32'd3255, 32'd3063,
    32'd2367, 32'd1791, 32'd1751, 32'd1591},
  parameter int DEFAULT_IDX     = 6,
  parameter int EFFECT_ID       = 3,
  parameter int ENABLE_BIT      = 7,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WRAP            = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              key3,
  input  logic              key2,
  input  logic [9:0]        SW,
  output logic [FREQ_W-1:0] frequency,
  output logic [IDX_W-1:0]  preset_idx,
  output logic              changed,
  output logic              disabled
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  // Bit 0 carries the down key, bit 1 the up key.
  logic [1:0]    key_raw;
  logic [1:0]    s1_q, s2_q, deb_q, armed_q, press_q, step;
  logic [DW-1:0] cnt_q [2];
  logic [1:0]    fill_q;
  logic          gate, dn, up;
  logic [IDX_W-1:0] idx_d;
  logic          unused_sw;

  assign key_raw   = {key2, key3};
  assign unused_sw = ^SW;

  // armed_q blocks a key that was already held through reset until it is seen released.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q    <= '1;
      s2_q    <= '1;
      deb_q   <= '1;
      armed_q <= '0;
      press_q <= '0;
      fill_q  <= '0;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (fill_q == 2'd2 && s2_q[k]) armed_q[k] <= 1'b1;
        if (s2_q[k] == deb_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[k]   <= '0;
          deb_q[k]   <= s2_q[k];
          press_q[k] <= ~s2_q[k] & armed_q[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

`ifdef RING_MOD_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} rpt_state_e;
  rpt_state_e    st_q   [2];
  logic [RW-1:0] rcnt_q [2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 2; k++) begin
        st_q[k]   <= IDLE;
        rcnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (st_q[k])
          IDLE: begin
            rcnt_q[k] <= '0;
            if (press_q[k]) st_q[k] <= HELD;
          end
          HELD: begin
            if (deb_q[k]) begin
              st_q[k]   <= IDLE;
              rcnt_q[k] <= '0;
            end else if (rcnt_q[k] == RW'(REPEAT_DELAY - 1)) begin
              st_q[k]   <= REPEAT;
              rcnt_q[k] <= '0;
            end else begin
              rcnt_q[k] <= rcnt_q[k] + 1'b1;
            end
          end
          default: begin
            if (deb_q[k]) begin
              st_q[k]   <= IDLE;
              rcnt_q[k] <= '0;
            end else if (rcnt_q[k] == RW'(REPEAT_PERIOD - 1)) begin
              rcnt_q[k] <= '0;
            end else begin
              rcnt_q[k] <= rcnt_q[k] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    step = press_q;
    for (int k = 0; k < 2; k++) begin
      if (!deb_q[k]) begin
        if (st_q[k] == HELD && rcnt_q[k] == RW'(REPEAT_DELAY - 1)) step[k] = 1'b1;
        if (st_q[k] == REPEAT && rcnt_q[k] == RW'(REPEAT_PERIOD - 1)) step[k] = 1'b1;
      end
    end
  end
`else
  localparam int unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;
  assign step = press_q;
`endif

  assign gate = (SW[3:0] == 4'(EFFECT_ID));
  assign dn   = step[0] & gate;
  assign up   = step[1] & gate;

  // Coincident down and up steps cancel.
  always_comb begin
    idx_d = preset_idx;
    if (dn && !up) begin
      if (preset_idx == '0)
        idx_d = (WRAP != 0) ? IDX_W'(NUM_PRESETS - 1) : '0;
      else
        idx_d = preset_idx - 1'b1;
    end else if (up && !dn) begin
      if (preset_idx == IDX_W'(NUM_PRESETS - 1))
        idx_d = (WRAP != 0) ? '0 : IDX_W'(NUM_PRESETS - 1);
      else
        idx_d = preset_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      preset_idx <= IDX_W'(DEFAULT_IDX);
      frequency  <= PRESET_TABLE[DEFAULT_IDX*FREQ_W +: FREQ_W];
      changed    <= 1'b0;
      disabled   <= 1'b1;
    end else begin
      preset_idx <= idx_d;
      frequency  <= PRESET_TABLE[int'(idx_d)*FREQ_W +: FREQ_W];
      changed    <= (idx_d != preset_idx);
      disabled   <= ~SW[ENABLE_BIT];
    end
  end

endmodule

// File: tb/tb_ring_mod_preset_sequencer.sv
// Directed bench: two instances (saturating and wrapping) share every input.
module tb_ring_mod_preset_sequencer;
  localparam int FREQ_W = 32;
  localparam int IDX_W  = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic key3 = 1'b1;
  logic key2 = 1'b1;
  logic [9:0] SW = 10'h083;
  logic [FREQ_W-1:0] freq0, freq1;
  logic [IDX_W-1:0]  idx0, idx1;
  logic chg0, chg1, dis0, dis1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ring_mod_preset_sequencer #(.DEBOUNCE_CYCLES(4), .WRAP(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut0 (
    .CLK(CLK), .RST(RST), .key3(key3), .key2(key2), .SW(SW),
    .frequency(freq0), .preset_idx(idx0), .changed(chg0), .disabled(dis0));

  ring_mod_preset_sequencer #(.DEBOUNCE_CYCLES(4), .WRAP(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut1 (
    .CLK(CLK), .RST(RST), .key3(key3), .key2(key2), .SW(SW),
    .frequency(freq1), .preset_idx(idx1), .changed(chg1), .disabled(dis1));

  typedef struct {
    logic        k3;
    logic        k2;
    logic [9:0]  sw;
    logic [3:0]  i0;
    logic [31:0] f0;
    int          p0;
    logic [3:0]  i1;
    logic [31:0] f1;
    int          p1;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive the keys low for 'hold' cycles, then released, over 'total' cycles.
  task automatic run_press(input logic k3p, input logic k2p, input logic [9:0] sw,
                           input int hold, input int total,
                           output int p0, output int p1, output int first0);
    SW = sw;
    key3 = ~k3p;
    key2 = ~k2p;
    p0 = 0; p1 = 0; first0 = 0;
    for (int i = 1; i <= total; i++) begin
      tick();
      if (chg0) begin
        p0++;
        if (first0 == 0) first0 = i;
      end
      if (chg1) p1++;
      if (i == hold) begin
        key3 = 1'b1;
        key2 = 1'b1;
      end
    end
  endtask

  initial begin
    int p0, p1, f0;
    tbl[0] = '{1'b0, 1'b1, 10'h083, 4'd7, 32'd4111, 0, 4'd0, 32'd1591, 1};
    tbl[1] = '{1'b1, 1'b0, 10'h082, 4'd7, 32'd4111, 0, 4'd0, 32'd1591, 0};
    tbl[2] = '{1'b1, 1'b0, 10'h083, 4'd6, 32'd3551, 1, 4'd7, 32'd4111, 1};
    tbl[3] = '{1'b1, 1'b0, 10'h083, 4'd5, 32'd3255, 1, 4'd6, 32'd3551, 1};
    tbl[4] = '{1'b0, 1'b1, 10'h084, 4'd5, 32'd3255, 0, 4'd6, 32'd3551, 0};
    tbl[5] = '{1'b1, 1'b0, 10'h003, 4'd4, 32'd3063, 1, 4'd5, 32'd3255, 1};
    tbl[6] = '{1'b0, 1'b1, 10'h083, 4'd5, 32'd3255, 1, 4'd6, 32'd3551, 1};

    repeat (3) tick();
    RST = 1'b0;
    check("rst_freq", freq0, 3551);
    check("rst_idx", idx0, 6);
    check("rst_disabled", dis0, 1);
    check("rst_changed", chg0, 0);
    tick();
    check("enable_after_rst", dis0, 0);
    repeat (4) tick();

    run_press(1'b0, 1'b1, 10'h083, 8, 20, p0, p1, f0);
    check("up_latency", f0, 7);
    check("up_pulses", p0, 1);
    check("up_idx", idx0, 7);
    check("up_freq", freq0, 4111);
    check("up_idx_wrapdut", idx1, 7);

    run_press(1'b0, 1'b1, 10'h083, 3, 15, p0, p1, f0);
    check("glitch_pulses0", p0, 0);
    check("glitch_pulses1", p1, 0);
    check("glitch_idx1", idx1, 7);

    SW = 10'h003;
    check("disabled_hold", dis0, 0);
    tick();
    check("disabled_1cyc", dis0, 1);
    SW = 10'h083;
    tick();

    for (int v = 0; v < 7; v++) begin
      run_press(tbl[v].k3, tbl[v].k2, tbl[v].sw, 8, 20, p0, p1, f0);
      check($sformatf("vec%0d_idx0", v), idx0, tbl[v].i0);
      check($sformatf("vec%0d_freq0", v), freq0, tbl[v].f0);
      check($sformatf("vec%0d_pulses0", v), p0, tbl[v].p0);
      check($sformatf("vec%0d_idx1", v), idx1, tbl[v].i1);
      check($sformatf("vec%0d_freq1", v), freq1, tbl[v].f1);
      check($sformatf("vec%0d_pulses1", v), p1, tbl[v].p1);
    end

    run_press(1'b1, 1'b1, 10'h083, 8, 20, p0, p1, f0);
    check("simul_idx0", idx0, 5);
    check("simul_idx1", idx1, 6);
    check("simul_pulses", p0 + p1, 0);

    // Key held across reset must not step until released and pressed again.
    key2 = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    check("rst_mid_idx0", idx0, 6);
    check("rst_mid_idx1", idx1, 6);
    p0 = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (chg0 || chg1) p0++;
      if (i == 20) key2 = 1'b1;
    end
    check("held_no_step", p0, 0);
    check("held_idx", idx0, 6);
    run_press(1'b0, 1'b1, 10'h083, 8, 20, p0, p1, f0);
    check("repress_idx", idx0, 7);
    check("repress_pulses", p0, 1);
    check("repress_freq1", freq1, 4111);

`ifdef RING_MOD_AUTO_REPEAT_EN
    begin
      int pos [3];
      int n;
      RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      repeat (5) tick();
      n = 0;
      key3 = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (chg0) begin
          if (n < 3) pos[n] = i;
          n++;
        end
        if (i == 18) key3 = 1'b1;
      end
      check("rpt_count", n, 3);
      check("rpt_pos0", pos[0], 7);
      check("rpt_pos1", pos[1], 17);
      check("rpt_pos2", pos[2], 22);
      check("rpt_idx", idx0, 3);
      check("rpt_freq", freq0, 2367);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
